fetch_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the hazard detection unit.
- Holds the program counter and selects the next PC from PC+4, branch, jump or jump-register targets.
- Owns the IF/ID pipeline register.
- Obeys the hazard unit's PCWrite / IF_ID_Write / IF_ID_flush controls and keeps saturating stall and flush counters for debug.

---
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC register, next-PC select, IF/ID register, debug counters
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             PCWrite,
   input  logic             IF_ID_Write,
   input  logic             IF_ID_flush,
   input  logic             branch,
   input  logic             jump,
   input  logic             jumpReg,
   input  logic [31:0]      BranchTarget,
   input  logic [31:0]      JumpTarget,
   input  logic [31:0]      JumpRegTarget,
   input  logic [31:0]      Instruction_in,
   input  logic             CountClear,
   output logic [31:0]      PC_out,
   output logic [31:0]      IF_ID_Instruction,
   output logic [31:0]      IF_ID_PCPlus4,
   output logic             IF_ID_Valid,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam logic [31:0]      ALIGN_MASK = 32'hFFFF_FFFC;
   localparam logic [31:0]      PC_INIT    = RESET_PC & ALIGN_MASK;
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        run;

   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic [31:0] pc_sel;
   logic [31:0] next_pc;
   logic        stall_cycle;

   // BOOT lasts one cycle after reset release, then RUN until the next reset
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state and the run qualifier that gates every other state update
   always_comb begin
      state_d = state_q;
      run     = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            run = 1'b1;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // next-PC select: jumpReg > jump > branch > sequential; low two bits always cleared
   always_comb begin
      pc_plus4 = pc_q + 32'd4;
      if (jumpReg) begin
         pc_sel = JumpRegTarget;
      end else if (jump) begin
         pc_sel = JumpTarget;
      end else if (branch) begin
         pc_sel = BranchTarget;
      end else begin
         pc_sel = pc_plus4;
      end
      next_pc     = pc_sel & ALIGN_MASK;
      stall_cycle = !PCWrite && !IF_ID_Write && !IF_ID_flush;
   end

   // PC register; redirects seen while PCWrite=0 are dropped, the hazard unit re-presents them
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pc_q <= PC_INIT;
      end else if (run && PCWrite) begin
         pc_q <= next_pc;
      end
   end

   assign PC_out = pc_q;

   // IF/ID register: flush beats write beats hold
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         IF_ID_Instruction <= 32'h0;
         IF_ID_PCPlus4     <= 32'h0;
         IF_ID_Valid       <= 1'b0;
      end else if (run) begin
         if (IF_ID_flush) begin
            IF_ID_Instruction <= 32'h0;
            IF_ID_PCPlus4     <= 32'h0;
            IF_ID_Valid       <= 1'b0;
         end else if (IF_ID_Write) begin
            IF_ID_Instruction <= Instruction_in;
            IF_ID_PCPlus4     <= pc_plus4;
            IF_ID_Valid       <= 1'b1;
         end
      end
   end

   // saturating stall/flush counters; clear wins over a same-cycle increment
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else if (run) begin
         if (CountClear) begin
            StallCount <= '0;
            FlushCount <= '0;
         end else begin
            if (stall_cycle && (StallCount != CNT_MAX)) begin
               StallCount <= StallCount + CNT_ONE;
            end
            if (IF_ID_flush && (FlushCount != CNT_MAX)) begin
               FlushCount <= FlushCount + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        PCWrite, IF_ID_Write, IF_ID_flush;
   logic        branch, jump, jumpReg, CountClear;
   logic [31:0] BranchTarget, JumpTarget, JumpRegTarget;
   logic [31:0] Instruction_in;

   logic [31:0] a_pc, a_ins, a_p4;
   logic        a_val;
   logic [15:0] a_sc, a_fc;
   logic [31:0] w_pc, w_ins, w_p4;
   logic        w_val;
   logic [15:0] w_sc, w_fc;
   logic [31:0] s_pc, s_ins, s_p4;
   logic        s_val;
   logic [1:0]  s_sc, s_fc;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model state
   bit          m_boot;
   logic [31:0] m_pc, m_ins, m_p4, m_wpc, m_wp4;
   logic        m_val;
   int          m_sc, m_fc, m_ssc, m_sfc;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return {a[15:0] ^ 16'h1234, ~a[15:0]};
   endfunction

   assign Instruction_in = imem(a_pc);

   always #5 Clk = ~Clk;

   fetch_stage dut_a (
      .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
      .IF_ID_flush(IF_ID_flush), .branch(branch), .jump(jump), .jumpReg(jumpReg),
      .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .JumpRegTarget(JumpRegTarget),
      .Instruction_in(Instruction_in), .CountClear(CountClear), .PC_out(a_pc),
      .IF_ID_Instruction(a_ins), .IF_ID_PCPlus4(a_p4), .IF_ID_Valid(a_val),
      .StallCount(a_sc), .FlushCount(a_fc)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
      .IF_ID_flush(IF_ID_flush), .branch(branch), .jump(jump), .jumpReg(jumpReg),
      .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .JumpRegTarget(JumpRegTarget),
      .Instruction_in(Instruction_in), .CountClear(CountClear), .PC_out(w_pc),
      .IF_ID_Instruction(w_ins), .IF_ID_PCPlus4(w_p4), .IF_ID_Valid(w_val),
      .StallCount(w_sc), .FlushCount(w_fc)
   );

   fetch_stage #(.CNT_W(2)) dut_s (
      .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
      .IF_ID_flush(IF_ID_flush), .branch(branch), .jump(jump), .jumpReg(jumpReg),
      .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .JumpRegTarget(JumpRegTarget),
      .Instruction_in(Instruction_in), .CountClear(CountClear), .PC_out(s_pc),
      .IF_ID_Instruction(s_ins), .IF_ID_PCPlus4(s_p4), .IF_ID_Valid(s_val),
      .StallCount(s_sc), .FlushCount(s_fc)
   );

   task automatic model_reset();
      m_boot = 1'b1;
      m_pc = 32'h0; m_ins = 32'h0; m_p4 = 32'h0; m_val = 1'b0;
      m_wpc = 32'hFFFF_FFFC; m_wp4 = 32'h0;
      m_sc = 0; m_fc = 0; m_ssc = 0; m_sfc = 0;
   endtask

   task automatic set_ctrl(input bit pw, input bit iw, input bit fl,
                           input bit br, input bit jp, input bit jr);
      PCWrite = pw; IF_ID_Write = iw; IF_ID_flush = fl;
      branch = br; jump = jp; jumpReg = jr;
   endtask

   // advance the model by one clock using the inputs currently applied, then let the DUT clock
   task automatic tick();
      logic [31:0] redir, tgt, wtgt;
      bit          has_redir, stalled;
      if (m_boot) begin
         m_boot = 1'b0;
      end else begin
         has_redir = jumpReg || jump || branch;
         redir = jumpReg ? JumpRegTarget : (jump ? JumpTarget : BranchTarget);
         redir = (redir / 4) * 4;
         tgt   = has_redir ? redir : m_pc + 32'd4;
         wtgt  = has_redir ? redir : m_wpc + 32'd4;
         stalled = !PCWrite && !IF_ID_Write && !IF_ID_flush;
         if (IF_ID_flush) begin
            m_ins = 0; m_p4 = 0; m_val = 0; m_wp4 = 0;
         end else if (IF_ID_Write) begin
            m_ins = imem(m_pc); m_p4 = m_pc + 32'd4; m_val = 1; m_wp4 = m_wpc + 32'd4;
         end
         if (PCWrite) begin
            m_pc = tgt; m_wpc = wtgt;
         end
         if (CountClear) begin
            m_sc = 0; m_fc = 0; m_ssc = 0; m_sfc = 0;
         end else begin
            if (stalled) begin
               m_sc  = (m_sc  < 65535) ? m_sc  + 1 : 65535;
               m_ssc = (m_ssc < 3)     ? m_ssc + 1 : 3;
            end
            if (IF_ID_flush) begin
               m_fc  = (m_fc  < 65535) ? m_fc  + 1 : 65535;
               m_sfc = (m_sfc < 3)     ? m_sfc + 1 : 3;
            end
         end
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      set_ctrl(1, 1, 0, 0, 0, 0);
      CountClear = 0; BranchTarget = 0; JumpTarget = 0; JumpRegTarget = 0;
      model_reset();
      #12;
      n_cmp++;
      if ({a_pc, a_ins, a_p4, a_val} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_ifid: pc=%h ins=%h p4=%h v=%b want 0/0/0/0", a_pc, a_ins, a_p4, a_val);
      end
      n_cmp++;
      if ({a_sc, a_fc, s_sc, s_fc} !== 36'h0) begin
         n_bad++;
         $display("FAIL reset_cnt: %h %h %h %h want 0", a_sc, a_fc, s_sc, s_fc);
      end
      n_cmp++;
      if (w_pc !== 32'hFFFF_FFFC) begin
         n_bad++;
         $display("FAIL reset_pc_param: got %h want fffffffc", w_pc);
      end
      @(posedge Clk);
      #1;
      Reset = 1'b1;
   endtask

   task automatic test_boot_flow();
      set_ctrl(1, 1, 0, 0, 0, 0);
      tick();
      n_cmp++;
      if ({a_pc, a_val, a_ins, w_pc} !== {32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC}) begin
         n_bad++;
         $display("FAIL boot_hold: pc=%h v=%b ins=%h wpc=%h want 0/0/0/fffffffc", a_pc, a_val, a_ins, w_pc);
      end
      tick();
      n_cmp++;
      if ({w_pc, w_p4} !== {32'h0, 32'h0}) begin
         n_bad++;
         $display("FAIL pc_wrap: pc=%h p4=%h want 0/0", w_pc, w_p4);
      end
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) tick();
         n_cmp++;
         if ({a_pc, a_ins, a_p4, a_val} !== {32'(4 * i), imem(32'(4 * (i - 1))), 32'(4 * i), 1'b1}) begin
            n_bad++;
            $display("FAIL seq_fetch%0d: pc=%h ins=%h p4=%h v=%b want pc=%h", i, a_pc, a_ins, a_p4, a_val, 4 * i);
         end
      end
   endtask

   task automatic test_stall();
      set_ctrl(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if ({a_pc, a_ins, a_p4, a_val} !== {32'h10, imem(32'hC), 32'h10, 1'b1}) begin
            n_bad++;
            $display("FAIL stall_hold%0d: pc=%h ins=%h p4=%h v=%b want 10/%h/10/1", i, a_pc, a_ins, a_p4, a_val, imem(32'hC));
         end
      end
      n_cmp++;
      if ({a_sc, 14'h0, s_sc} !== {16'd2, 14'h0, 2'd2}) begin
         n_bad++;
         $display("FAIL stall_count: got %0d/%0d want 2/2", a_sc, s_sc);
      end
      set_ctrl(1, 1, 0, 0, 0, 0);
      tick();
      n_cmp++;
      if ({a_pc, a_ins, a_p4} !== {32'h14, imem(32'h10), 32'h14}) begin
         n_bad++;
         $display("FAIL stall_resume: pc=%h ins=%h p4=%h want 14/%h/14", a_pc, a_ins, a_p4, imem(32'h10));
      end
   endtask

   task automatic test_priority();
      BranchTarget = 32'h40; JumpTarget = 32'h80;
      set_ctrl(1, 1, 1, 1, 1, 0);
      tick();
      n_cmp++;
      if ({a_pc, a_ins, a_p4, a_val, a_fc} !== {32'h80, 32'h0, 32'h0, 1'b0, 16'd1}) begin
         n_bad++;
         $display("FAIL jump_over_branch: pc=%h ins=%h p4=%h v=%b fc=%0d want 80/0/0/0/1", a_pc, a_ins, a_p4, a_val, a_fc);
      end
   endtask

   task automatic test_jr_stall();
      JumpRegTarget = 32'h203;
      set_ctrl(0, 0, 0, 0, 0, 1);
      tick();
      n_cmp++;
      if ({a_pc, a_sc} !== {32'h80, 16'd3}) begin
         n_bad++;
         $display("FAIL jr_held: pc=%h sc=%0d want 80/3", a_pc, a_sc);
      end
      set_ctrl(1, 0, 1, 0, 0, 1);
      tick();
      n_cmp++;
      if ({a_pc, a_val, a_fc} !== {32'h200, 1'b0, 16'd2}) begin
         n_bad++;
         $display("FAIL jr_redirect: pc=%h v=%b fc=%0d want 200/0/2", a_pc, a_val, a_fc);
      end
      set_ctrl(1, 1, 0, 0, 0, 0);
      tick();
      n_cmp++;
      if ({a_pc, a_ins, a_p4, a_val} !== {32'h204, imem(32'h200), 32'h204, 1'b1}) begin
         n_bad++;
         $display("FAIL jr_target_fetch: pc=%h ins=%h p4=%h v=%b want 204/%h/204/1", a_pc, a_ins, a_p4, a_val, imem(32'h200));
      end
   endtask

   task automatic test_saturate();
      set_ctrl(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) tick();
      n_cmp++;
      if ({a_sc, 14'h0, s_sc} !== {16'd8, 14'h0, 2'd3}) begin
         n_bad++;
         $display("FAIL stall_saturate: got %0d/%0d want 8/3", a_sc, s_sc);
      end
      CountClear = 1'b1;
      tick();
      CountClear = 1'b0;
      n_cmp++;
      if ({a_sc, a_fc, s_sc, s_fc} !== 36'h0) begin
         n_bad++;
         $display("FAIL clear_over_inc: %0d %0d %0d %0d want all 0", a_sc, a_fc, s_sc, s_fc);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         set_ctrl($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(4) == 0,
                  $urandom_range(5) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0);
         BranchTarget = $urandom; JumpTarget = $urandom; JumpRegTarget = $urandom;
         CountClear = ($urandom_range(15) == 0);
         tick();
         n_cmp++;
         if ({a_pc, w_pc, w_p4} !== {m_pc, m_wpc, m_wp4}) begin
            n_bad++;
            $display("FAIL rand_pc@%0d: pc=%h wpc=%h wp4=%h want %h/%h/%h", i, a_pc, w_pc, w_p4, m_pc, m_wpc, m_wp4);
         end
         n_cmp++;
         if ({a_ins, a_p4, a_val} !== {m_ins, m_p4, m_val}) begin
            n_bad++;
            $display("FAIL rand_ifid@%0d: ins=%h p4=%h v=%b want %h/%h/%b", i, a_ins, a_p4, a_val, m_ins, m_p4, m_val);
         end
         n_cmp++;
         if ({a_sc, a_fc, s_sc, s_fc} !== {m_sc[15:0], m_fc[15:0], m_ssc[1:0], m_sfc[1:0]}) begin
            n_bad++;
            $display("FAIL rand_cnt@%0d: %0d %0d %0d %0d want %0d %0d %0d %0d", i, a_sc, a_fc, s_sc, s_fc, m_sc, m_fc, m_ssc, m_sfc);
         end
      end
      CountClear = 1'b0;
   endtask

   task automatic test_reset_mid();
      set_ctrl(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      #3;
      Reset = 1'b0;
      #1;
      n_cmp++;
      if ({a_pc, a_ins, a_p4, a_val, a_sc, a_fc} !== {32'h0, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0}) begin
         n_bad++;
         $display("FAIL mid_reset_a: pc=%h ins=%h p4=%h v=%b sc=%0d fc=%0d want all 0", a_pc, a_ins, a_p4, a_val, a_sc, a_fc);
      end
      n_cmp++;
      if ({s_sc, s_fc, w_pc, w_val} !== {2'd0, 2'd0, 32'hFFFF_FFFC, 1'b0}) begin
         n_bad++;
         $display("FAIL mid_reset_other: ssc=%0d sfc=%0d wpc=%h wv=%b want 0/0/fffffffc/0", s_sc, s_fc, w_pc, w_val);
      end
      model_reset();
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      set_ctrl(1, 1, 0, 0, 0, 0);
      tick();
      tick();
      n_cmp++;
      if ({a_pc, a_ins, a_p4, a_val} !== {32'h4, imem(32'h0), 32'h4, 1'b1}) begin
         n_bad++;
         $display("FAIL restart_fetch: pc=%h ins=%h p4=%h v=%b want 4/%h/4/1", a_pc, a_ins, a_p4, a_val, imem(32'h0));
      end
   endtask

   initial begin
      test_reset();
      test_boot_flow();
      test_stall();
      test_priority();
      test_jr_stall();
      test_saturate();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
